// File: rtl/seq_det_pkg.sv
// seq_det_pkg: elaboration-time helpers for the parametrised sequence detector
package seq_det_pkg;
  localparam int MAX_LEN = 32;
  function automatic int state_w(input int len);
    return $clog2(len + 1);
  endfunction
  function automatic bit len_ok(input int len);
    return len >= 2 && len <= MAX_LEN;
  endfunction
  function automatic bit cnt_w_ok(input int w);
    return w >= 1 && w <= 32;
  endfunction
  // KMP transition: longest prefix of the pattern that is a suffix of (prefix_k, bit_in)
  function automatic int next_state(input logic [31:0] pattern, input int len, input int state,
                                    input logic bit_in, input logic overlap);
    int k, m, res;
    logic ok, sb;
    if (state > len) return 0;
    k = (state == len && !overlap) ? 0 : state;
    res = 0;
    for (int j = 1; j <= k + 1 && j <= len; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        m = k + 1 - j + i;
        if (m < k) sb = pattern[len-1-m];
        else sb = bit_in;
        if (sb != pattern[len-1-i]) ok = 1'b0;
      end
      if (ok) res = j;
    end
    return res;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and async active-low reset
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (clr) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: Moore serial pattern detector with qualify enable and saturating match count
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         d_in,
  input  logic                         clr_cnt,
  output logic                         d_out,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [state_w(PAT_LEN)-1:0]  state_dbg
);
  localparam int                SW    = state_w(PAT_LEN);
  localparam logic [31:0]       PAT32 = 32'(PATTERN);
  localparam logic [SW-1:0]     MATCH = SW'(PAT_LEN);
  if (!len_ok(PAT_LEN)) begin : g_bad_len
    $error("PAT_LEN must be 2..32");
  end
  if (!cnt_w_ok(CNT_W)) begin : g_bad_cnt
    $error("CNT_W must be 1..32");
  end
  logic [SW-1:0] trans [2**SW][2];
  logic [SW-1:0] state, nxt;
  logic          inc;
  // Constant transition table; unreachable encodings fall back to S0
  for (genvar s = 0; s < 2**SW; s++) begin : g_st
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int T = next_state(PAT32, PAT_LEN, s, b == 1, OVERLAP);
      assign trans[s][b] = T[SW-1:0];
    end
  end
  always_comb begin
    nxt = en ? trans[state][d_in] : state;
    inc = en && nxt == MATCH;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= '0;
    else state <= nxt;
  assign d_out     = state == MATCH;
  assign state_dbg = state;
  sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (inc),
    .clr  (clr_cnt),
    .count(match_cnt)
  );
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed table and corner-case checks over four parameterisations
module tb_seq_detector_param;
  logic clk = 0, rst = 0, en = 0, d_in = 0, clr_cnt = 0;
  logic d0, d1, d2, d3;
  logic [7:0] c0, c1, c3;
  logic [1:0] c2, s3;
  logic [2:0] s0, s1, s2;
  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  seq_detector_param u0 (.clk(clk), .rst(rst), .en(en), .d_in(d_in), .clr_cnt(clr_cnt),
                         .d_out(d0), .match_cnt(c0), .state_dbg(s0));
  seq_detector_param #(.OVERLAP(1'b0)) u1 (.clk(clk), .rst(rst), .en(en), .d_in(d_in), .clr_cnt(clr_cnt),
                         .d_out(d1), .match_cnt(c1), .state_dbg(s1));
  seq_detector_param #(.CNT_W(2)) u2 (.clk(clk), .rst(rst), .en(en), .d_in(d_in), .clr_cnt(clr_cnt),
                         .d_out(d2), .match_cnt(c2), .state_dbg(s2));
  seq_detector_param #(.PAT_LEN(2), .PATTERN(2'b11)) u3 (.clk(clk), .rst(rst), .en(en), .d_in(d_in),
                         .clr_cnt(clr_cnt), .d_out(d3), .match_cnt(c3), .state_dbg(s3));

  typedef struct {
    logic en, d, clr;
    logic o0; int n0, st0;
    logic o1; int n1, st1;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic d, input logic c);
    @(negedge clk);
    en = e; d_in = d; clr_cnt = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; en = 0; d_in = 0; clr_cnt = 0;
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    tv[0] = '{1, 1, 0, 0, 0, 1, 0, 0, 1};
    tv[1] = '{1, 0, 0, 0, 0, 2, 0, 0, 2};
    tv[2] = '{1, 1, 0, 0, 0, 3, 0, 0, 3};
    tv[3] = '{1, 1, 0, 1, 1, 4, 1, 1, 4};
    tv[4] = '{1, 0, 0, 0, 1, 2, 0, 1, 0};
    tv[5] = '{1, 1, 0, 0, 1, 3, 0, 1, 1};
    tv[6] = '{1, 1, 0, 1, 2, 4, 0, 1, 1};

    #12;
    chk("reset d_out", d0, 0);
    chk("reset cnt", c0, 0);
    chk("reset state", s0, 0);
    chk("reset cnt u2", c2, 0);
    @(negedge clk);
    rst = 1;

    // Overlap vs non-overlap on 1,0,1,1,0,1,1
    foreach (tv[i]) begin
      step(tv[i].en, tv[i].d, tv[i].clr);
      chk($sformatf("ovl d_out[%0d]", i), d0, tv[i].o0);
      chk($sformatf("ovl cnt[%0d]", i), c0, tv[i].n0);
      chk($sformatf("ovl state[%0d]", i), s0, tv[i].st0);
      chk($sformatf("novl d_out[%0d]", i), d1, tv[i].o1);
      chk($sformatf("novl cnt[%0d]", i), c1, tv[i].n1);
      chk($sformatf("novl state[%0d]", i), s1, tv[i].st1);
    end

    // en=0 holds state, including holding MATCH
    do_reset();
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, i[0], 0);
      chk("en hold state", s0, 3);
      chk("en hold d_out", d0, 0);
    end
    step(1, 1, 0);
    chk("resume d_out", d0, 1);
    chk("resume cnt", c0, 1);
    step(0, 0, 0);
    chk("match hold d_out", d0, 1);
    chk("match hold cnt", c0, 1);
    step(1, 0, 0);
    chk("after hold d_out", d0, 0);
    chk("after hold state", s0, 2);

    // CNT_W=2 saturation, clear beats increment
    do_reset();
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
    chk("sat cnt m1", c2, 1);
    for (int m = 2; m <= 5; m++) begin
      step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
      chk($sformatf("sat d_out m%0d", m), d2, 1);
      chk($sformatf("sat cnt m%0d", m), c2, m > 3 ? 3 : m);
    end
    chk("wide cnt m5", c0, 5);
    step(1, 0, 0); step(1, 1, 0); step(1, 1, 1);
    chk("clr cnt u2", c2, 0);
    chk("clr cnt u0", c0, 0);
    chk("clr keeps d_out", d2, 1);
    step(1, 0, 0);
    chk("post clr cnt", c2, 0);

    // Async reset mid-pattern
    do_reset();
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    chk("pre rst state", s0, 3);
    #2 rst = 0;
    #1;
    chk("async rst state", s0, 0);
    chk("async rst d_out", d0, 0);
    @(negedge clk);
    rst = 1;
    step(1, 1, 0);
    chk("post rst d_out", d0, 0);
    chk("post rst state", s0, 1);
    step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
    chk("post rst match", d0, 1);
    chk("post rst cnt", c0, 1);

    // Periodic pattern 11 with overlap: MATCH -> MATCH
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0);
      chk($sformatf("p11 d_out[%0d]", i), d3, i > 0);
      chk($sformatf("p11 cnt[%0d]", i), c3, i);
      chk($sformatf("p11 state[%0d]", i), s3, i > 0 ? 2 : 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Moore sequence detector: recognises a compile-time serial bit pattern of configurable length on a single-bit input stream. Overlapping or non-overlapping matching is selected by parameter. Adds an input-qualify enable and a saturating match counter with synchronous clear. Sits on serial data paths as a frame/sync-word spotter feeding control logic.

## Interface
- PAT_LEN, 4, pattern length in bits; legal range 2..32 (elaboration error otherwise)
- PATTERN, 4'b1011, pattern value [PAT_LEN-1:0]; MSB is the first bit received
- OVERLAP, 1, 1 = overlapping match, 0 = non-overlapping
- CNT_W, 8, match counter width, legal 1..32
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- en  input  1  d_in qualifier; bit consumed only on an edge where en=1
- d_in  input  1  serial data bit
- clr_cnt  input  1  synchronous clear of match_cnt
- d_out  output  1  Moore match flag; high while FSM is in MATCH state
- match_cnt  output  CNT_W  number of matches since reset/clear, saturating
- state_dbg  output  $clog2(PAT_LEN+1)  current state index, for debug

## Operation
- States S0..S(PAT_LEN): Sk = first k pattern bits matched; S(PAT_LEN) = MATCH.
- Consumed bit b in state Sk (k<PAT_LEN): next = largest j ≤ k+1 such that the last j bits of (prefix_k, b) equal the first j pattern bits (KMP transition); computed from parameters at elaboration, no runtime tables.
- From MATCH, OVERLAP=1: next = KMP transition from the full pattern plus b (reuses the longest proper border).
- From MATCH, OVERLAP=0: next = transition from S0 with b (S1 if b equals PATTERN[PAT_LEN-1], else S0).
- en=0: state holds; d_out holds; no count.
- d_out = (state == MATCH); pure Moore, no combinational path from d_in.
- match_cnt increments by 1 on each edge that enters MATCH, including MATCH→MATCH (possible only for OVERLAP=1 with periodic patterns, e.g. 11).
- match_cnt saturates at 2^CNT_W−1; further matches are ignored.
- clr_cnt=1: match_cnt ← 0 on that edge; clear beats a simultaneous increment. FSM is unaffected by clr_cnt.
- Reset: state ← S0, d_out = 0, match_cnt = 0, state_dbg = 0, immediately on rst falling (asynchronous); release is synchronised by the integrator.

## Timing
- Latency: d_out rises on the same rising edge that samples the final pattern bit with en=1; visible one cycle after that bit is presented.
- d_out width = 1 cycle per match when en stays high; extends while en=0 holds MATCH.
- match_cnt updates on the same edge as d_out rising; the two are always coherent.
- rst asserted mid-pattern aborts the partial match; no pulse or count is produced for bits sampled before reset.
- Throughput: one bit per clock, no stall.

## Structure
- Package seq_det_pkg: function next_state(pattern, len, state, bit, overlap) returning the KMP transition; state-width localparam helper; parameter-legality checks.
- Sub-module sat_counter (WIDTH, inc, clr, count; async active-low rst) holds match_cnt; FSM and Moore output stay in the top.
- State register is a binary index of width $clog2(PAT_LEN+1), not one-hot.

## Test plan
- Default params, en=1, stream 1,0,1,1,0,1,1 → d_out high after bits 4 and 7, match_cnt=2, state_dbg=4 at both.
- OVERLAP=0, same stream → one pulse after bit 4, match_cnt=1, final state_dbg=1.
- Default, stream 1,0,1 then en=0 for 3 cycles with d_in toggling, then en=1 with 1 → single pulse on the resumed bit, match_cnt=1.
- CNT_W=2, 5 back-to-back matches of 1011 → match_cnt 1,2,3,3,3; clr_cnt together with the 6th match → match_cnt=0.
- rst pulsed low after 1,0,1 is received, then 1 → no pulse, state_dbg=1; then 0,1,1 → one pulse.
- PAT_LEN=2, PATTERN=2'b11, OVERLAP=1, stream 1,1,1,1 → d_out high for 3 consecutive cycles, match_cnt=3.
